sha256_compression: RTL and testbench

- Registered single round of the SHA-256 compression function: one round per clock.
- Each cycle it consumes the working variables a..h, the current 16-word message-schedule window and the round constant K[t]. It produces the next working variables and the schedule window advanced by one word.
- The miner iterates it 64 times by feeding outputs back to inputs. An external sequencer supplies K[t] and does the final IV/feed-forward addition.

---
 rtl/sha256_compression.sv | 81 ++++++++
 tb/tb_sha256_compression.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sha256_compression.sv
// One registered SHA-256 compression round: working variables and 16-word schedule window in,
// next-round values out one clock later. Define SHA256_COMPRESSION_VALID_EN for validIn/validOut.
module sha256_compression (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  k,
  input  logic [511:0] wIn,     // word i at bits [32*i +: 32]; wIn[0] = W[t]
  input  logic [255:0] varsIn,  // {a,b,c,d,e,f,g,h}, a in the top word
`ifdef SHA256_COMPRESSION_VALID_EN
  input  logic         validIn,
  output logic         validOut,
`endif
  output logic [511:0] wOut,
  output logic [255:0] varsOut
);

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  logic [31:0]  w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
  logic [31:0]  w_big_sigma0, w_big_sigma1, w_ch, w_maj;
  logic [31:0]  w_t1, w_t2, w_sig0, w_sig1, w_w_new;
  logic [255:0] w_vars_next;
  logic [511:0] w_w_next;
  logic         w_en;

  logic [255:0] r_vars;
  logic [511:0] r_w;

  assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = varsIn;

  always_comb begin
    w_big_sigma0 = rotr(w_a, 2) ^ rotr(w_a, 13) ^ rotr(w_a, 22);
    w_big_sigma1 = rotr(w_e, 6) ^ rotr(w_e, 11) ^ rotr(w_e, 25);
    w_ch         = (w_e & w_f) ^ (~w_e & w_g);
    w_maj        = (w_a & w_b) ^ (w_a & w_c) ^ (w_b & w_c);
    w_t1         = w_h + w_big_sigma1 + w_ch + k + wIn[31:0];
    w_t2         = w_big_sigma0 + w_maj;
    w_vars_next  = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};
  end

  // Schedule expansion uses window-relative taps: W[t+16] from W[t+14], W[t+9], W[t+1], W[t].
  always_comb begin
    w_sig0   = rotr(wIn[63:32], 7) ^ rotr(wIn[63:32], 18) ^ (wIn[63:32] >> 3);
    w_sig1   = rotr(wIn[479:448], 17) ^ rotr(wIn[479:448], 19) ^ (wIn[479:448] >> 10);
    w_w_new  = w_sig1 + wIn[319:288] + w_sig0 + wIn[31:0];
    w_w_next = {w_w_new, wIn[511:32]};
  end

`ifdef SHA256_COMPRESSION_VALID_EN
  logic r_valid;

  assign w_en     = validIn;
  assign validOut = r_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= validIn;
    end
  end
`else
  assign w_en = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vars <= '0;
      r_w    <= '0;
    end else if (w_en) begin
      r_vars <= w_vars_next;
      r_w    <= w_w_next;
    end
  end

  assign varsOut = r_vars;
  assign wOut    = r_w;

endmodule

// File: tb/tb_sha256_compression.sv
// Scoreboard bench for sha256_compression: reference-model expectations are queued as each
// round is driven and popped after the clock edge, plus known-answer checks on the "abc" block.
module tb_sha256_compression;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  k;
  logic [511:0] wIn, wOut;
  logic [255:0] varsIn, varsOut;

  int n_checks = 0;
  int n_pass   = 0;
  logic [767:0] sb_q[$];

  always #5 clk = ~clk;

  sha256_compression dut (
    .clk     (clk),
    .reset   (reset),
    .k       (k),
    .wIn     (wIn),
    .varsIn  (varsIn),
    .wOut    (wOut),
    .varsOut (varsOut)
  );

  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [511:0] W_ABC = {32'h00000018, 448'h0, 32'h61626380};
  localparam logic [255:0] EXP_R0 = {32'h5d6aebcd, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372,
                                     32'hfa2a4622, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab};
  localparam logic [511:0] EXP_W0 = {32'h61626380, 32'h00000018, 448'h0};

  logic [31:0] kt[64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] dbl;
    dbl = {x, x} >> n;
    return dbl[31:0];
  endfunction

  function automatic logic [767:0] ref_round(input logic [255:0] v, input logic [511:0] w,
                                             input logic [31:0] kk);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    logic [31:0] wa[16];
    logic [511:0] wn;
    for (int i = 0; i < 16; i++) wa[i] = w[32*i +: 32];
    {a, b, c, d, e, f, g, h} = v;
    t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + kk + wa[0];
    t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    for (int i = 0; i < 15; i++) wn[32*i +: 32] = wa[i+1];
    wn[511:480] = (rr(wa[14], 17) ^ rr(wa[14], 19) ^ (wa[14] >> 10)) + wa[9]
                + (rr(wa[1], 7) ^ rr(wa[1], 18) ^ (wa[1] >> 3)) + wa[0];
    return {t1 + t2, a, b, c, d + t1, e, f, g, wn};
  endfunction

  // Drives one round, queues its expected result, and checks it after the edge.
  task automatic run_round(input logic rst, input logic [255:0] v, input logic [511:0] w,
                           input logic [31:0] kk, input string tag);
    logic [767:0] exp_v;
    @(negedge clk);
    reset  = rst;
    varsIn = v;
    wIn    = w;
    k      = kk;
    sb_q.push_back(rst ? 768'h0 : ref_round(v, w, kk));
    @(posedge clk);
    #1;
    n_checks++;
    if (sb_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      exp_v = sb_q.pop_front();
      if ({varsOut, wOut} !== exp_v)
        $display("FAIL %s: got vars=%h w=%h expected vars=%h w=%h", tag, varsOut, wOut,
                 exp_v[767:512], exp_v[511:0]);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      run_round(1'b1, {8{$urandom()}}, {16{$urandom()}}, $urandom(), "reset_edge");
      n_checks++;
      if (varsOut !== 256'h0 || wOut !== 512'h0)
        $display("FAIL reset_zero: got vars=%h w=%h expected all zero", varsOut, wOut);
      else n_pass++;
    end
  endtask

  task automatic check_round0(input string tag);
    n_checks++;
    if (varsOut !== EXP_R0) $display("FAIL %s_vars: got %h expected %h", tag, varsOut, EXP_R0);
    else n_pass++;
    n_checks++;
    if (wOut !== EXP_W0) $display("FAIL %s_w: got %h expected %h", tag, wOut, EXP_W0);
    else n_pass++;
  endtask

  task automatic test_round0();
    run_round(1'b0, IV, W_ABC, kt[0], "round0");
    check_round0("round0");
  endtask

  task automatic test_schedule_round1();
    run_round(1'b0, varsOut, wOut, kt[1], "round1");
    n_checks++;
    if (wOut[511:480] !== 32'h000f0000)
      $display("FAIL w17: got %h expected 000f0000", wOut[511:480]);
    else n_pass++;
  endtask

  task automatic test_full_block();
    logic [255:0] exp_final, exp_digest, digest;
    exp_final  = {32'h506e3058, 32'hd39a2165, 32'h04d24d6c, 32'hb85e2ce9,
                  32'h5ef50f24, 32'hfb121210, 32'h948d25b6, 32'h961f4894};
    exp_digest = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                  32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    for (int t = 0; t < 64; t++)
      run_round(1'b0, (t == 0) ? IV : varsOut, (t == 0) ? W_ABC : wOut, kt[t], "block_round");
    n_checks++;
    if (varsOut !== exp_final)
      $display("FAIL block_final: got %h expected %h", varsOut, exp_final);
    else n_pass++;
    for (int i = 0; i < 8; i++) digest[32*i +: 32] = varsOut[32*i +: 32] + IV[32*i +: 32];
    n_checks++;
    if (digest !== exp_digest)
      $display("FAIL block_digest: got %h expected %h", digest, exp_digest);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [255:0] exp_vars;
    logic [511:0] exp_w;
    exp_vars = {32'hfffffff9, {3{32'hffffffff}}, 32'hfffffffa, {3{32'hffffffff}}};
    exp_w    = {32'h203ffffc, {15{32'hffffffff}}};
    run_round(1'b0, {8{32'hffffffff}}, {16{32'hffffffff}}, 32'hffffffff, "wrap_model");
    n_checks++;
    if (varsOut !== exp_vars) $display("FAIL wrap_vars: got %h expected %h", varsOut, exp_vars);
    else n_pass++;
    n_checks++;
    if (wOut !== exp_w) $display("FAIL wrap_w: got %h expected %h", wOut, exp_w);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int t = 0; t < 30; t++)
      run_round(1'b0, (t == 0) ? IV : varsOut, (t == 0) ? W_ABC : wOut, kt[t], "pre_reset");
    run_round(1'b1, varsOut, wOut, kt[30], "mid_reset");
    n_checks++;
    if (varsOut !== 256'h0 || wOut !== 512'h0)
      $display("FAIL mid_reset_zero: got vars=%h w=%h expected all zero", varsOut, wOut);
    else n_pass++;
    run_round(1'b0, IV, W_ABC, kt[0], "restart");
    check_round0("restart");
  endtask

  initial begin
    reset  = 1'b1;
    k      = '0;
    wIn    = '0;
    varsIn = '0;
    test_reset();
    test_round0();
    test_schedule_round1();
    test_full_block();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
